ps2_scancode_rx: RTL

PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

---
 rtl/ps2_scancode_rx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises the bus, deframes bytes,
// folds E0/F0 prefixes into events and buffers them in a FIFO.
module ps2_scancode_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [7:0]                  evt_code,
    output logic                        evt_ext,
    output logic                        evt_break,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        err_parity,
    output logic                        err_frame,
    output logic                        err_timeout,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   bit_in;

    state_t         state;
    state_t         state_nx;
    logic [7:0]     shreg;
    logic [2:0]     bit_idx;
    logic           par_bit;
    logic [TW-1:0]  timer;
    logic           tmo;
    logic           byte_ok;
    logic           perr;
    logic           ferr;
    logic           terr;

    logic           byte_vld;
    logic [7:0]     byte_q;
    logic           ext_f;
    logic           brk_f;
    logic           push;
    logic           pop;
    logic           wr;
    logic           full;
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [9:0]     mem [FIFO_DEPTH];
    logic [9:0]     head;

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = dat_sync[SYNC_STAGES-1];

    // Synchronisers idle high so reset looks like a quiet bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    assign tmo = (state != IDLE) && !fall &&
                 (timer == TW'(TIMEOUT_CYCLES - 1));

    // Next state and per-frame result strobes
    always_comb begin
        state_nx = state;
        byte_ok  = 1'b0;
        perr     = 1'b0;
        ferr     = 1'b0;
        terr     = 1'b0;
        if (tmo) begin
            state_nx = IDLE;
            terr     = 1'b1;
        end else if (fall) begin
            unique case (state)
                IDLE:   if (!bit_in) state_nx = DATA;
                DATA:   if (bit_idx == 3'd7) state_nx = PARITY;
                PARITY: state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    if (!bit_in)                   ferr    = 1'b1;
                    else if (!(^{shreg, par_bit})) perr    = 1'b1;
                    else                           byte_ok = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Bit shifter, parity capture and inter-edge watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_idx <= '0;
            par_bit <= 1'b0;
            timer   <= '0;
        end else begin
            if (fall || state == IDLE) timer <= '0;
            else                       timer <= timer + 1'b1;
            if (fall && state == IDLE) bit_idx <= '0;
            if (fall && state == DATA) begin
                shreg   <= {bit_in, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (fall && state == PARITY) par_bit <= bit_in;
        end
    end

    // Register completed byte and error pulses one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_vld    <= 1'b0;
            byte_q      <= '0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            byte_vld    <= byte_ok;
            err_parity  <= perr;
            err_frame   <= ferr;
            err_timeout <= terr;
            if (byte_ok) byte_q <= shreg;
        end
    end

    // Prefix flags; any receive error drops a half-built sequence
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else if (err_parity | err_frame | err_timeout) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else if (byte_vld) begin
            if (byte_q == 8'hE0) begin
                ext_f <= 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_f <= 1'b1;
            end else begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
            end
        end
    end

    assign push = byte_vld && byte_q != 8'hE0 && byte_q != 8'hF0;
    assign full = fifo_count == (AW + 1)'(FIFO_DEPTH);
    assign evt_valid = fifo_count != '0;
    assign pop  = evt_valid & evt_ready;
    assign wr   = push & (~full | pop);
    assign overflow = push & full & ~pop;

    // Event storage; contents only visible while counted valid
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= {byte_q, ext_f, brk_f};
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (wr && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!wr && pop) fifo_count <= fifo_count - 1'b1;
        end
    end

    assign head      = mem[rptr];
    assign evt_code  = evt_valid ? head[9:2] : 8'h00;
    assign evt_ext   = evt_valid & head[1];
    assign evt_break = evt_valid & head[0];

endmodule
